// File: rtl/biquad_coeff_sequencer.sv
// biquad_coeff_sequencer: WISHBONE shadow bank for biquad coefficients
// that streams masked per-channel loads and issues update strobes.
module biquad_coeff_sequencer #(
  parameter int NCHAN      = 8,
  parameter int NCOEFF     = 8,
  parameter int COEFF_BITS = 18,
  parameter int ADR_BITS   = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADR_BITS-1:0]   wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic                  global_update_i,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic [NCHAN-1:0]      coeff_wr_o,
  output logic [NCHAN-1:0]      coeff_update_o,
  output logic                  busy_o
);

  localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int KW   = $clog2(NCOEFF);
  localparam int IW   = CW + KW;
  localparam int NENT = NCHAN * NCOEFF;
  localparam int WW   = ADR_BITS - 2;
  localparam int SW   = ADR_BITS - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UPD
  } state_e;

  logic rs1_q, rs2_q, rst_n;

  // Reset asserts asynchronously, releases two clk_i edges later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rs1_q <= 1'b0;
      rs2_q <= 1'b0;
    end else begin
      rs1_q <= 1'b1;
      rs2_q <= rs1_q;
    end
  end

  assign rst_n = rs2_q;

  logic [COEFF_BITS-1:0] shadow_q [2**IW];

  logic          ack_q, we_q;
  logic [3:0]    sel_q;
  logic [WW-1:0] widx_q;
  logic [31:0]   wdat_q, rdat_q, rdat_d;

  logic [NCHAN-1:0] mask_q, lmask_q, upd_q, wr_q;
  logic             err_q, pend_q, upda_q;
  logic [COEFF_BITS-1:0] dat_q;

  state_e  state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, first_ch, nxt_ch;
  logic [KW-1:0] k_q, k_d;
  logic [NCHAN-1:0] lmask_d;
  logic upda_d, nxt_ok;

  logic          req;
  logic [WW-1:0] widx;
  logic [SW-1:0] sidx;
  logic          sh_hit, shq_hit;

  assign req    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign widx   = wb_adr_i[ADR_BITS-1:2];
  assign sidx   = widx[SW-1:0];
  assign sh_hit = widx[WW-1] &
                  ({1'b0, sidx} < (SW+1)'(NENT));
  assign shq_hit = widx_q[WW-1] &
                   ({1'b0, widx_q[SW-1:0]} < (SW+1)'(NENT));

  logic wr_ok, wr_ctrl, wr_mask, wr_stat, wr_sh;
  logic start_req, start_go;

  assign wr_ok   = ack_q & we_q & (sel_q == 4'hF);
  assign wr_ctrl = wr_ok & (widx_q == WW'(0));
  assign wr_mask = wr_ok & (widx_q == WW'(1));
  assign wr_stat = wr_ok & (widx_q == WW'(2));
  assign wr_sh   = wr_ok & shq_hit;

  assign start_req = wr_ctrl & wdat_q[0];
  assign start_go  = start_req & ~busy_o & (|mask_q);

  assign busy_o = (state_q == S_LOAD) | (|wr_q);

  // Read mux evaluated in the request cycle, registered into the ack
  always_comb begin
    rdat_d = '0;
    if (widx[WW-1]) begin
      if (sh_hit) rdat_d = 32'($signed(shadow_q[IW'(sidx)]));
    end else if (widx == WW'(1)) begin
      rdat_d = 32'(mask_q);
    end else if (widx == WW'(2)) begin
      rdat_d = {30'b0, err_q, busy_o};
    end
  end

  // WB handshake: single-cycle ack, request latched for the ack cycle
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      rdat_q <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      widx_q <= '0;
      wdat_q <= '0;
    end else begin
      ack_q  <= req;
      rdat_q <= (req & ~wb_we_i) ? rdat_d : '0;
      if (req) begin
        we_q   <= wb_we_i;
        sel_q  <= wb_sel_i;
        widx_q <= widx;
        wdat_q <= wb_dat_i;
      end
    end
  end

  // Shadow storage survives reset; writes refused during a load
  always_ff @(posedge clk_i) begin
    if (wr_sh & ~busy_o)
      shadow_q[IW'(widx_q[SW-1:0])] <= wdat_q[COEFF_BITS-1:0];
  end

  // Lowest masked channel, and next masked channel above ch_q
  always_comb begin
    first_ch = '0;
    nxt_ch   = '0;
    nxt_ok   = 1'b0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask_q[i]) first_ch = CW'(i);
      if (lmask_q[i] && (CW'(i) > ch_q)) begin
        nxt_ch = CW'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  // Sequencer next state: walk masked channels, NCOEFF words each
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    k_d     = k_q;
    lmask_d = lmask_q;
    upda_d  = upda_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = S_LOAD;
          ch_d    = first_ch;
          k_d     = '0;
          lmask_d = mask_q;
          upda_d  = wdat_q[1];
        end
      end
      S_LOAD: begin
        if (k_q == KW'(NCOEFF - 1)) begin
          k_d = '0;
          if (nxt_ok) ch_d = nxt_ch;
          else state_d = upda_q ? S_UPD : S_IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_UPD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      k_q     <= '0;
      lmask_q <= '0;
      upda_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      k_q     <= k_d;
      lmask_q <= lmask_d;
      upda_q  <= upda_d;
    end
  end

  // One-cycle pipelined shadow read feeding the coefficient port
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      dat_q <= '0;
    end else if (state_q == S_LOAD) begin
      wr_q  <= NCHAN'(1) << ch_q;
      dat_q <= shadow_q[{ch_q, k_q}];
    end else begin
      wr_q  <= '0;
    end
  end

  // Control registers, error flag, pending global update, strobes
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      err_q  <= 1'b0;
      pend_q <= 1'b0;
      upd_q  <= '0;
    end else begin
      if (wr_mask) mask_q <= wdat_q[NCHAN-1:0];
      if (wr_stat & wdat_q[1]) err_q <= 1'b0;
      else if (busy_o & (wr_sh | start_req)) err_q <= 1'b1;
      if (state_q == S_LOAD) begin
        pend_q <= pend_q | global_update_i;
        upd_q  <= '0;
      end else begin
        pend_q <= 1'b0;
        upd_q  <= (pend_q | global_update_i) ? '1 : '0;
        if (state_q == S_UPD) upd_q <= lmask_q |
          ((pend_q | global_update_i) ? '1 : '0);
      end
    end
  end

  assign wb_ack_o       = ack_q;
  assign wb_dat_o       = rdat_q;
  assign wb_err_o       = 1'b0;
  assign wb_rty_o       = 1'b0;
  assign coeff_dat_o    = dat_q;
  assign coeff_wr_o     = wr_q;
  assign coeff_update_o = upd_q;

endmodule
